// File: rtl/bp_stat_monitor_if.sv
// bp_stat_monitor_if
// Read-back port of the branch-prediction statistics monitor. A requester
// raises rd_req_i with a channel/kind select and gets exactly one response
// (rd_vld_o + rd_data_o) on the following cycle.
//
// Parameters:
//   NUM_CH    - number of predictor channels (sets the rd_ch_i width)
//   CNT_WIDTH - width of the returned counter value
//
// Signals:
//   rd_req_i   read request (pulse or held high)
//   rd_ch_i    channel select for kinds 1..3
//   rd_kind_i  0 instructions, 1 branches, 2 misses, 3 window misses
//   rd_vld_o   response valid
//   rd_data_o  response data
//
// Modports:
//   master - the requester (bench or profiler)
//   slave  - the monitor
interface bp_stat_monitor_if #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 rd_req_i;
    logic [CH_W-1:0]      rd_ch_i;
    logic [1:0]           rd_kind_i;
    logic                 rd_vld_o;
    logic [CNT_WIDTH-1:0] rd_data_o;

    modport master (
        output rd_req_i, rd_ch_i, rd_kind_i,
        input  rd_vld_o, rd_data_o
    );

    modport slave (
        input  rd_req_i, rd_ch_i, rd_kind_i,
        output rd_vld_o, rd_data_o
    );
endinterface

// File: rtl/bp_stat_monitor.sv
// bp_stat_monitor
// Multi-channel branch-prediction performance monitor. Counts retired
// instructions, resolved branches and mispredictions per predictor channel
// with saturating totals, and optionally a per-channel miss count over a
// sliding window of 2^WINDOW_LOG2 branches. Counters are read back through
// a one-request/one-response port with one cycle of latency.
//
// Optional feature macro: BP_STAT_WINDOW_EN
//   defined   - per-channel window miss logic is built (rd_kind_i = 3)
//   undefined - no window registers; rd_kind_i = 3 reads as 0
//
// Ports:
//   clk_i        core clock
//   rst_i        asynchronous active-high reset
//   start_i      enter RUN (from IDLE or FROZEN)
//   stop_i       enter FROZEN (from RUN)
//   clear_i      zero all counters, return to IDLE
//   instr_vld_i  one instruction valid this cycle
//   br_instr_i   per-channel branch resolved this cycle
//   br_miss_i    per-channel misprediction, qualified by br_instr_i
//   rd           read port (bp_stat_monitor_if.slave)
//   state_o      0 IDLE, 1 RUN, 2 FROZEN
//   ovf_o        sticky flag, set when any total counter saturates
module bp_stat_monitor #(
    parameter int NUM_CH      = 2,
    parameter int CNT_WIDTH   = 32,
    parameter int WINDOW_LOG2 = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              clear_i,
    input  logic              instr_vld_i,
    input  logic [NUM_CH-1:0] br_instr_i,
    input  logic [NUM_CH-1:0] br_miss_i,
    bp_stat_monitor_if.slave  rd,
    output logic [1:0]        state_o,
    output logic              ovf_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CH_W:0]        NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] instr_cnt;
    logic [CNT_WIDTH-1:0] br_cnt   [NUM_CH];
    logic [CNT_WIDTH-1:0] miss_cnt [NUM_CH];
    logic                 sat_hit;
    logic                 ch_ok;
    logic [CNT_WIDTH-1:0] rd_mux;

    assign state_o = state;
    assign ch_ok   = ({1'b0, rd.rd_ch_i} < NUM_CH_V);

    // stop_i outranks start_i, so a stop in IDLE/FROZEN also blocks a start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else if (clear_i) begin
            state <= ST_IDLE;
        end else if (stop_i) begin
            if (state == ST_RUN)
                state <= ST_FROZEN;
        end else if (start_i) begin
            if (state == ST_IDLE || state == ST_FROZEN)
                state <= ST_RUN;
        end
    end

    // Flags any increment that lands a total counter on its ceiling.
    always_comb begin
        sat_hit = 1'b0;
        if (state == ST_RUN) begin
            if (instr_vld_i && instr_cnt == CNT_MAX - 1'b1)
                sat_hit = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (br_instr_i[c] && br_cnt[c] == CNT_MAX - 1'b1)
                    sat_hit = 1'b1;
                if (br_instr_i[c] && br_miss_i[c] && miss_cnt[c] == CNT_MAX - 1'b1)
                    sat_hit = 1'b1;
            end
        end
    end

    // Saturating totals; clear_i wins over any event in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_cnt <= '0;
            ovf_o     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                br_cnt[c]   <= '0;
                miss_cnt[c] <= '0;
            end
        end else if (clear_i) begin
            instr_cnt <= '0;
            ovf_o     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                br_cnt[c]   <= '0;
                miss_cnt[c] <= '0;
            end
        end else if (state == ST_RUN) begin
            if (sat_hit)
                ovf_o <= 1'b1;
            if (instr_vld_i && instr_cnt != CNT_MAX)
                instr_cnt <= instr_cnt + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (br_instr_i[c] && br_cnt[c] != CNT_MAX)
                    br_cnt[c] <= br_cnt[c] + 1'b1;
                if (br_instr_i[c] && br_miss_i[c] && miss_cnt[c] != CNT_MAX)
                    miss_cnt[c] <= miss_cnt[c] + 1'b1;
            end
        end
    end

`ifdef BP_STAT_WINDOW_EN
    logic [WINDOW_LOG2-1:0] win_idx  [NUM_CH];
    logic [WINDOW_LOG2:0]   win_acc  [NUM_CH];
    logic [WINDOW_LOG2:0]   win_miss [NUM_CH];

    // The branch that wraps the index closes the window: its own miss bit
    // is folded into the published count and the accumulator restarts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                win_idx[c]  <= '0;
                win_acc[c]  <= '0;
                win_miss[c] <= '0;
            end
        end else if (clear_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                win_idx[c]  <= '0;
                win_acc[c]  <= '0;
                win_miss[c] <= '0;
            end
        end else if (state == ST_RUN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (br_instr_i[c]) begin
                    win_idx[c] <= win_idx[c] + 1'b1;
                    if (&win_idx[c]) begin
                        win_miss[c] <= win_acc[c] + {{WINDOW_LOG2{1'b0}}, br_miss_i[c]};
                        win_acc[c]  <= '0;
                    end else begin
                        win_acc[c] <= win_acc[c] + {{WINDOW_LOG2{1'b0}}, br_miss_i[c]};
                    end
                end
            end
        end
    end
`endif

    // Selects from the registered counters, i.e. before this cycle's events.
    always_comb begin
        rd_mux = '0;
        case (rd.rd_kind_i)
            2'd0: rd_mux = instr_cnt;
            2'd1: if (ch_ok) rd_mux = br_cnt[rd.rd_ch_i];
            2'd2: if (ch_ok) rd_mux = miss_cnt[rd.rd_ch_i];
`ifdef BP_STAT_WINDOW_EN
            2'd3: if (ch_ok) rd_mux = CNT_WIDTH'(win_miss[rd.rd_ch_i]);
`endif
            default: rd_mux = '0;
        endcase
    end

    // A read in the clear cycle still returns its pre-clear snapshot; a
    // clear without a read zeroes the held data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd.rd_vld_o  <= 1'b0;
            rd.rd_data_o <= '0;
        end else if (rd.rd_req_i) begin
            rd.rd_vld_o  <= 1'b1;
            rd.rd_data_o <= rd_mux;
        end else begin
            rd.rd_vld_o <= 1'b0;
            if (clear_i)
                rd.rd_data_o <= '0;
        end
    end
endmodule

// File: tb/tb_bp_stat_monitor.sv
// tb_bp_stat_monitor
// Self-checking bench for bp_stat_monitor with NUM_CH=2, CNT_WIDTH=8,
// WINDOW_LOG2=2. Covers counting, gating, saturation, simultaneous control,
// back-to-back reads, window (or its absence when BP_STAT_WINDOW_EN is not
// defined) and asynchronous reset during a held read.
module tb_bp_stat_monitor;
    localparam int NUM_CH      = 2;
    localparam int CNT_WIDTH   = 8;
    localparam int WINDOW_LOG2 = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       stop_i;
    logic       clear_i;
    logic       instr_vld_i;
    logic [1:0] br_instr_i;
    logic [1:0] br_miss_i;
    logic [1:0] state_o;
    logic       ovf_o;

    int checks = 0;
    int errors = 0;

    bp_stat_monitor_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) rd_if ();

    bp_stat_monitor #(
        .NUM_CH      (NUM_CH),
        .CNT_WIDTH   (CNT_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .clear_i     (clear_i),
        .instr_vld_i (instr_vld_i),
        .br_instr_i  (br_instr_i),
        .br_miss_i   (br_miss_i),
        .rd          (rd_if),
        .state_o     (state_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic [1:0] kind;
        logic       ch;
        logic [7:0] expected;
    } rd_vec_t;

    rd_vec_t run_vecs [6];
    rd_vec_t gate_vecs [5];

    // Advance n clock edges, leaving time 1 unit after the last edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [1:0] bi,
                                 input logic [1:0] bm, input int n);
        instr_vld_i = iv;
        br_instr_i  = bi;
        br_miss_i   = bm;
        step(n);
        instr_vld_i = 1'b0;
        br_instr_i  = 2'b00;
        br_miss_i   = 2'b00;
    endtask

    task automatic readCounter(input string name, input logic [1:0] kind,
                               input logic ch, input logic [7:0] expected);
        rd_if.rd_req_i  = 1'b1;
        rd_if.rd_kind_i = kind;
        rd_if.rd_ch_i   = ch;
        step(1);
        rd_if.rd_req_i  = 1'b0;
        checkOutput({name, "_vld"}, 32'(rd_if.rd_vld_o), 32'd1);
        checkOutput(name, 32'(rd_if.rd_data_o), 32'(expected));
    endtask

    task automatic pulseStart();
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic pulseStop();
        stop_i = 1'b1;
        step(1);
        stop_i = 1'b0;
    endtask

    task automatic pulseClear();
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
    endtask

    initial begin
        run_vecs[0] = '{"run_instr",     2'd0, 1'b0, 8'd10};
        run_vecs[1] = '{"run_instr_ch1", 2'd0, 1'b1, 8'd10};
        run_vecs[2] = '{"run_br0",       2'd1, 1'b0, 8'd10};
        run_vecs[3] = '{"run_miss0",     2'd2, 1'b0, 8'd3};
        run_vecs[4] = '{"run_br1",       2'd1, 1'b1, 8'd0};
        run_vecs[5] = '{"run_miss1",     2'd2, 1'b1, 8'd0};

        gate_vecs[0] = '{"gate_instr", 2'd0, 1'b0, 8'd12};
        gate_vecs[1] = '{"gate_br0",   2'd1, 1'b0, 8'd10};
        gate_vecs[2] = '{"gate_miss0", 2'd2, 1'b0, 8'd3};
        gate_vecs[3] = '{"gate_br1",   2'd1, 1'b1, 8'd1};
        gate_vecs[4] = '{"gate_miss1", 2'd2, 1'b1, 8'd1};

        rst_i           = 1'b1;
        start_i         = 1'b0;
        stop_i          = 1'b0;
        clear_i         = 1'b0;
        instr_vld_i     = 1'b0;
        br_instr_i      = 2'b00;
        br_miss_i       = 2'b00;
        rd_if.rd_req_i  = 1'b0;
        rd_if.rd_ch_i   = 1'b0;
        rd_if.rd_kind_i = 2'd0;
        step(3);
        rst_i = 1'b0;
        step(1);

        // Reset state
        checkOutput("rst_state", 32'(state_o), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_o), 32'd0);
        checkOutput("rst_vld", 32'(rd_if.rd_vld_o), 32'd0);
        checkOutput("rst_data", 32'(rd_if.rd_data_o), 32'd0);

        // Basic counting: 10 instructions, 10 ch0 branches, 3 misses
        pulseStart();
        checkOutput("state_run", 32'(state_o), 32'd1);
        applyStimulus(1'b1, 2'b01, 2'b01, 3);
        applyStimulus(1'b1, 2'b01, 2'b00, 7);
        for (int i = 0; i < 6; i++)
            readCounter(run_vecs[i].name, run_vecs[i].kind, run_vecs[i].ch,
                        run_vecs[i].expected);

        // Gating: unqualified miss, stop-cycle counted, frozen and start-cycle not
        applyStimulus(1'b0, 2'b00, 2'b10, 1);
        stop_i      = 1'b1;
        instr_vld_i = 1'b1;
        br_instr_i  = 2'b10;
        br_miss_i   = 2'b10;
        step(1);
        stop_i      = 1'b0;
        instr_vld_i = 1'b0;
        br_instr_i  = 2'b00;
        br_miss_i   = 2'b00;
        checkOutput("state_frozen", 32'(state_o), 32'd2);
        applyStimulus(1'b1, 2'b11, 2'b11, 2);
        start_i     = 1'b1;
        instr_vld_i = 1'b1;
        br_instr_i  = 2'b01;
        step(1);
        start_i     = 1'b0;
        instr_vld_i = 1'b0;
        br_instr_i  = 2'b00;
        checkOutput("state_resume", 32'(state_o), 32'd1);
        applyStimulus(1'b1, 2'b00, 2'b00, 1);
        pulseStop();
        for (int i = 0; i < 5; i++)
            readCounter(gate_vecs[i].name, gate_vecs[i].kind, gate_vecs[i].ch,
                        gate_vecs[i].expected);

        // Saturation
        pulseClear();
        checkOutput("clr_state", 32'(state_o), 32'd0);
        checkOutput("clr_ovf", 32'(ovf_o), 32'd0);
        readCounter("clr_instr", 2'd0, 1'b0, 8'd0);
        pulseStart();
        applyStimulus(1'b1, 2'b00, 2'b00, 254);
        readCounter("sat_instr_254", 2'd0, 1'b0, 8'd254);
        checkOutput("sat_ovf_254", 32'(ovf_o), 32'd0);
        applyStimulus(1'b1, 2'b00, 2'b00, 46);
        readCounter("sat_instr_300", 2'd0, 1'b0, 8'd255);
        checkOutput("sat_ovf", 32'(ovf_o), 32'd1);
        pulseStop();
        step(3);
        checkOutput("sat_ovf_sticky", 32'(ovf_o), 32'd1);

        // Read in the clear cycle returns the old value
        clear_i         = 1'b1;
        rd_if.rd_req_i  = 1'b1;
        rd_if.rd_kind_i = 2'd0;
        step(1);
        clear_i        = 1'b0;
        rd_if.rd_req_i = 1'b0;
        checkOutput("clr_rd_vld", 32'(rd_if.rd_vld_o), 32'd1);
        checkOutput("clr_rd_data", 32'(rd_if.rd_data_o), 32'd255);
        checkOutput("clr_rd_ovf", 32'(ovf_o), 32'd0);
        readCounter("clr_rd_after", 2'd0, 1'b0, 8'd0);

        // clear + stop + start in one cycle
        pulseStart();
        applyStimulus(1'b1, 2'b01, 2'b01, 2);
        clear_i = 1'b1;
        stop_i  = 1'b1;
        start_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        stop_i  = 1'b0;
        start_i = 1'b0;
        checkOutput("all3_state", 32'(state_o), 32'd0);
        readCounter("all3_instr", 2'd0, 1'b0, 8'd0);
        readCounter("all3_br0", 2'd1, 1'b0, 8'd0);
        readCounter("all3_miss0", 2'd2, 1'b0, 8'd0);

        // Back-to-back reads on channel 1
        pulseStart();
        applyStimulus(1'b1, 2'b10, 2'b10, 2);
        applyStimulus(1'b1, 2'b10, 2'b00, 3);
        applyStimulus(1'b1, 2'b00, 2'b00, 1);
        pulseStop();
        rd_if.rd_req_i  = 1'b1;
        rd_if.rd_ch_i   = 1'b1;
        rd_if.rd_kind_i = 2'd0;
        step(1);
        checkOutput("b2b_vld0", 32'(rd_if.rd_vld_o), 32'd1);
        checkOutput("b2b_instr", 32'(rd_if.rd_data_o), 32'd6);
        rd_if.rd_kind_i = 2'd1;
        step(1);
        checkOutput("b2b_vld1", 32'(rd_if.rd_vld_o), 32'd1);
        checkOutput("b2b_br1", 32'(rd_if.rd_data_o), 32'd5);
        rd_if.rd_kind_i = 2'd2;
        step(1);
        checkOutput("b2b_vld2", 32'(rd_if.rd_vld_o), 32'd1);
        checkOutput("b2b_miss1", 32'(rd_if.rd_data_o), 32'd2);
        rd_if.rd_req_i = 1'b0;
        step(1);
        checkOutput("b2b_vld_drop", 32'(rd_if.rd_vld_o), 32'd0);
        checkOutput("b2b_data_hold", 32'(rd_if.rd_data_o), 32'd2);

        // Window misses on channel 0
        pulseClear();
        pulseStart();
`ifdef BP_STAT_WINDOW_EN
        applyStimulus(1'b0, 2'b01, 2'b01, 1);
        applyStimulus(1'b0, 2'b01, 2'b00, 1);
        pulseStop();
        step(2);
        pulseStart();
        applyStimulus(1'b0, 2'b01, 2'b01, 2);
        readCounter("win_first", 2'd3, 1'b0, 8'd3);
        applyStimulus(1'b0, 2'b01, 2'b00, 2);
        readCounter("win_hold", 2'd3, 1'b0, 8'd3);
        applyStimulus(1'b0, 2'b01, 2'b00, 1);
        applyStimulus(1'b0, 2'b01, 2'b01, 1);
        readCounter("win_second", 2'd3, 1'b0, 8'd1);
        readCounter("win_miss0_total", 2'd2, 1'b0, 8'd4);
`else
        applyStimulus(1'b0, 2'b01, 2'b01, 4);
        readCounter("nowin_kind3", 2'd3, 1'b0, 8'd0);
        readCounter("nowin_br0", 2'd1, 1'b0, 8'd4);
`endif

        // Asynchronous reset during a held read
        rd_if.rd_req_i  = 1'b1;
        rd_if.rd_kind_i = 2'd1;
        rd_if.rd_ch_i   = 1'b0;
        step(2);
        checkOutput("arst_vld_before", 32'(rd_if.rd_vld_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("arst_vld", 32'(rd_if.rd_vld_o), 32'd0);
        checkOutput("arst_data", 32'(rd_if.rd_data_o), 32'd0);
        checkOutput("arst_state", 32'(state_o), 32'd0);
        rd_if.rd_req_i = 1'b0;
        step(1);
        rst_i = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_stat_monitor.md
# bp_stat_monitor

Multi-channel branch-prediction performance monitor for the pipelined 5-stage core benches and on-chip profiling. Counts retired instructions plus resolved branches and mispredictions for up to NUM_CH predictor instances running side by side. Keeps saturating totals and an optional sliding-window miss count per channel. Counters are read back through a one-request/one-response port, so predictor comparisons no longer depend on bench-side hierarchical probes.

## Interface
Parameters:
- NUM_CH, 2, number of predictor channels (1..8).
- CNT_WIDTH, 32, width of every total counter (8..64).
- WINDOW_LOG2, 6, window length is 2^WINDOW_LOG2 branches per channel (1..10).

Ports:
- clk_i  in  1  core clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  enter RUN.
- stop_i  in  1  enter FROZEN.
- clear_i  in  1  zero all counters and return to IDLE.
- instr_vld_i  in  1  one instruction valid in IF this cycle.
- br_instr_i  in  NUM_CH  bit c: a branch/jump resolved in EX/MEM on channel c this cycle.
- br_miss_i  in  NUM_CH  bit c: channel c flushed IF for that branch (misprediction). Qualified by br_instr_i[c].
- rd_req_i  in  1  read request, single-cycle pulse or held high.
- rd_ch_i  in  max(1,$clog2(NUM_CH))  channel select for kinds 1..3.
- rd_kind_i  in  2  selects the counter: 0 instructions, 1 branches[ch], 2 misses[ch], 3 window misses[ch].
- rd_vld_o  out  1  read response valid.
- rd_data_o  out  CNT_WIDTH  read response data.
- state_o  out  2  monitor state: 0 IDLE, 1 RUN, 2 FROZEN.
- ovf_o  out  1  sticky flag, set when any total counter saturates.

## Operation
- States:
  - IDLE: nothing counts. start_i goes to RUN.
  - RUN: counting. stop_i goes to FROZEN.
  - FROZEN: nothing counts; values are held. start_i resumes RUN without clearing.
  - clear_i from any state goes to IDLE.
- Priority within one cycle: clear_i > stop_i > start_i.
- Counting happens only while state is RUN:
  - instr_cnt += instr_vld_i.
  - br_cnt[c] += br_instr_i[c].
  - miss_cnt[c] += br_instr_i[c] & br_miss_i[c]. A miss without br_instr_i is ignored.
- Total counters saturate at 2^CNT_WIDTH-1 and never wrap. The first saturating increment sets ovf_o, which stays high until clear_i or rst_i.
- Window logic, per channel:
  - A WINDOW_LOG2-bit branch index and a (WINDOW_LOG2+1)-bit miss accumulator run alongside the totals.
  - On the branch where the index wraps from all-ones to 0, win_miss[c] is loaded with accumulator + that branch's miss bit, and the accumulator is reset to 0.
  - win_miss[c] is zero-extended to CNT_WIDTH on readout.
  - The window state is preserved across FROZEN and cleared by clear_i.
- Readout:
  - Reads are legal in every state.
  - The value returned is the selected counter as registered at the start of the request cycle, i.e. before that cycle's increment.
  - rd_ch_i >= NUM_CH returns 0.
  - rd_kind_i = 0 ignores rd_ch_i.
- Reset and clear: every counter, window register, accumulator and index goes to 0; state_o = IDLE; ovf_o = 0; rd_vld_o = 0; rd_data_o = 0.

## Timing
- Control input sampled in cycle t takes effect at t+1.
  - start_i at t: events at t are not counted; events from t+1 are.
  - stop_i at t: events at t are still counted; from t+1 nothing counts.
  - clear_i at t: events at t are discarded; counters read 0 from t+1.
- Events at t are visible to a read requested at t+1 or later.
- Read latency is 1 cycle: rd_req_i at t gives rd_vld_o = 1 and rd_data_o at t+1. rd_req_i held high gives one response per cycle.
- rd_data_o holds its last value while rd_vld_o = 0.
- rd_req_i and clear_i in the same cycle: the response carries the pre-clear value.
- rst_i asserted mid-read: rd_vld_o drops immediately, because the reset is asynchronous.

## Configuration
- BP_STAT_WINDOW_EN defined: the window logic described above is built.
- BP_STAT_WINDOW_EN undefined:
  - no window registers are synthesised;
  - rd_kind_i = 3 returns 0 with normal rd_vld_o timing;
  - the total counters, ovf_o and state behaviour are unchanged.

## Test plan
All scenarios use NUM_CH=2, CNT_WIDTH=8, WINDOW_LOG2=2.
- Reset then start_i: in RUN, 10 cycles with instr_vld_i=1, br_instr_i=2'b01 and br_miss_i=2'b01 on 3 of those cycles. Reads must return instr=10, br[0]=10, miss[0]=3, br[1]=0.
- Gating: br_miss_i=2'b10 with br_instr_i=0 gives miss[1]=0. Events in the stop_i cycle are counted; events in the start_i cycle are not.
- Saturation: 300 instructions in RUN. instr reads 255, ovf_o=1, and ovf_o stays 1 until clear_i.
- Window (macro defined): channel 0 branch miss pattern 1,0,1,1 then 0,0,0,1.
  - win_miss[0] reads 3 after the 4th branch and 1 after the 8th.
  - A FROZEN gap between the 2nd and 3rd branch leaves the results unchanged.
- Simultaneous events:
  - clear_i+stop_i+start_i in one cycle ends in IDLE with all counters 0.
  - rd_req_i in the clear_i cycle returns the old value.
  - Back-to-back reads with rd_kind_i=0,1,2 and rd_ch_i=1 give three consecutive rd_vld_o pulses with the correct data.
- Macro undefined: after 4 branches on channel 0, rd_kind_i=3 returns 0 one cycle later. Async rst_i during a held rd_req_i clears rd_vld_o without a clock edge.
